ccd_cds_sequencer: RTL and testbench

- Downstream consumer of the CCD clock-phase generator outputs (phi_p, phi_l1, phi_l2, phi_r).
- Tracks the pixel, line and frame position from the phase edges.
- Issues single-cycle correlated-double-sampling strobes: a reset-level sample after each phi_r fall and a signal-level sample after each phi_l1 fall.
- Provides column/row counters and line/frame markers to the ADC capture path.

---
 rtl/ccd_cds_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_ccd_cds_sequencer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/ccd_cds_sequencer.sv
// CCD correlated-double-sampling sequencer: tracks pixel/line/frame position from the clock phases and issues sample strobes.
// Strobes fire RST_DLY/SIG_DLY cycles after the phi_r/phi_l1 falling edge; col/row update the cycle after pix_valid.
// No backpressure: phases are free-running; `define CDS_SUB_EN adds a registered saturating reset-minus-signal output.
module ccd_cds_sequencer #(
   parameter int N_COLS  = 16,
   parameter int N_ROWS  = 16,
   parameter int RST_DLY = 2,
   parameter int SIG_DLY = 2,
   parameter int ADC_W   = 12
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enable,
   input  logic             phi_p,
   input  logic             phi_l1,
   input  logic             phi_l2,
   input  logic             phi_r,
   input  logic [ADC_W-1:0] adc_data,
   output logic             smp_rst,
   output logic             smp_sig,
   output logic             pix_valid,
   output logic [7:0]       col,
   output logic [7:0]       row,
   output logic             line_end,
   output logic             frame_end,
   output logic             busy,
   output logic             err,
   output logic [ADC_W-1:0] cds_out,
   output logic             cds_valid
);

   typedef enum logic [2:0] {
      IDLE, WAIT_ROW, WAIT_RST, DLY_RST, WAIT_SIG, DLY_SIG
   } state_t;

   localparam logic [7:0] LAST_COL = 8'(N_COLS - 1);
   localparam logic [7:0] LAST_ROW = 8'(N_ROWS - 1);
   localparam logic [3:0] RST_LOAD = 4'(RST_DLY - 1);
   localparam logic [3:0] SIG_LOAD = 4'(SIG_DLY - 1);

   state_t     state, state_nxt;
   logic [3:0] dly_cnt, dly_nxt;
   logic [7:0] col_nxt, row_nxt, row_inc;
   logic       phi_p_q, phi_l1_q, phi_l2_q, phi_r_q, enable_q;
   logic       p_fall, l1_fall, r_fall;
   logic       err_q, err_set;

   assign p_fall    = phi_p_q & ~phi_p;
   assign l1_fall   = phi_l1_q & ~phi_l1;
   assign r_fall    = phi_r_q & ~phi_r;
   assign row_inc   = (row == LAST_ROW) ? 8'd0 : row + 8'd1;
   assign pix_valid = smp_sig;
   assign busy      = (state != IDLE);
   assign err       = err_q | err_set;

   always_comb begin
      state_nxt = state;
      dly_nxt   = dly_cnt;
      col_nxt   = col;
      row_nxt   = row;
      smp_rst   = 1'b0;
      smp_sig   = 1'b0;
      line_end  = 1'b0;
      frame_end = 1'b0;
      err_set   = 1'b0;
      if (!enable) begin
         state_nxt = IDLE;
         dly_nxt   = 4'd0;
         col_nxt   = 8'd0;
         row_nxt   = 8'd0;
      end else begin
         err_set = phi_l1 & phi_l2 & phi_l1_q & phi_l2_q;
         case (state)
            IDLE: state_nxt = WAIT_ROW;
            WAIT_ROW: begin
               if (p_fall) begin
                  state_nxt = WAIT_RST;
                  col_nxt   = 8'd0;
               end
            end
            WAIT_RST: begin
               if (r_fall) begin
                  state_nxt = DLY_RST;
                  dly_nxt   = RST_LOAD;
               end
            end
            DLY_RST: begin
               if (dly_cnt == 4'd0) begin
                  smp_rst   = 1'b1;
                  state_nxt = WAIT_SIG;
               end else begin
                  dly_nxt = dly_cnt - 4'd1;
               end
            end
            WAIT_SIG: begin
               if (r_fall) err_set = 1'b1;
               if (l1_fall) begin
                  state_nxt = DLY_SIG;
                  dly_nxt   = SIG_LOAD;
               end
            end
            DLY_SIG: begin
               if (r_fall) err_set = 1'b1;
               if (dly_cnt == 4'd0) begin
                  smp_sig = 1'b1;
                  if (col < LAST_COL) begin
                     col_nxt   = col + 8'd1;
                     state_nxt = WAIT_RST;
                  end else begin
                     line_end  = 1'b1;
                     frame_end = (row == LAST_ROW);
                     col_nxt   = 8'd0;
                     row_nxt   = row_inc;
                     // A row transfer landing on the last strobe already starts the next line.
                     state_nxt = p_fall ? WAIT_RST : WAIT_ROW;
                  end
               end else begin
                  dly_nxt = dly_cnt - 4'd1;
               end
            end
            default: state_nxt = IDLE;
         endcase
         // Row transfer mid-line: abandon the current pixel and restart on the next row.
         if (p_fall && state != IDLE && state != WAIT_ROW && !line_end) begin
            err_set   = 1'b1;
            smp_rst   = 1'b0;
            smp_sig   = 1'b0;
            col_nxt   = 8'd0;
            row_nxt   = row_inc;
            dly_nxt   = 4'd0;
            state_nxt = WAIT_RST;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         dly_cnt  <= 4'd0;
         col      <= 8'd0;
         row      <= 8'd0;
         phi_p_q  <= 1'b0;
         phi_l1_q <= 1'b0;
         phi_l2_q <= 1'b0;
         phi_r_q  <= 1'b0;
         enable_q <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state    <= state_nxt;
         dly_cnt  <= dly_nxt;
         col      <= col_nxt;
         row      <= row_nxt;
         phi_p_q  <= phi_p;
         phi_l1_q <= phi_l1;
         phi_l2_q <= phi_l2;
         phi_r_q  <= phi_r;
         enable_q <= enable;
         if (enable_q && !enable) err_q <= 1'b0;
         else if (err_set)        err_q <= 1'b1;
      end
   end

`ifdef CDS_SUB_EN
   logic [ADC_W-1:0] rst_lvl;

   always_ff @(posedge clk) begin
      if (!rst_n || !enable) begin
         rst_lvl   <= '0;
         cds_out   <= '0;
         cds_valid <= 1'b0;
      end else begin
         cds_valid <= smp_sig;
         if (smp_rst) rst_lvl <= adc_data;
         if (smp_sig) cds_out <= (rst_lvl > adc_data) ? rst_lvl - adc_data : '0;
      end
   end
`else
   logic unused_adc;
   assign unused_adc = ^adc_data;
   assign cds_out    = '0;
   assign cds_valid  = 1'b0;
`endif

endmodule

// File: tb/tb_ccd_cds_sequencer.sv
// Directed bench for ccd_cds_sequencer: per-cycle vector table for the first pixel, then hand-written
// sequences for the nominal frame, short line, enable drop, stray phi_r, overlap and CDS subtraction.
module tb_ccd_cds_sequencer;
   localparam int N_COLS  = 4;
   localparam int N_ROWS  = 2;
   localparam int RST_DLY = 2;
   localparam int SIG_DLY = 3;
   localparam int ADC_W   = 12;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             enable = 1'b0;
   logic             phi_p = 1'b0, phi_l1 = 1'b0, phi_l2 = 1'b0, phi_r = 1'b0;
   logic [ADC_W-1:0] adc_data = '0;
   logic             smp_rst, smp_sig, pix_valid, line_end, frame_end, busy, err, cds_valid;
   logic [7:0]       col, row;
   logic [ADC_W-1:0] cds_out;

   int checks = 0;
   int errors = 0;
   int npix = 0, nle = 0, nfe = 0;

   ccd_cds_sequencer #(
      .N_COLS(N_COLS), .N_ROWS(N_ROWS), .RST_DLY(RST_DLY), .SIG_DLY(SIG_DLY), .ADC_W(ADC_W)
   ) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable),
      .phi_p(phi_p), .phi_l1(phi_l1), .phi_l2(phi_l2), .phi_r(phi_r),
      .adc_data(adc_data),
      .smp_rst(smp_rst), .smp_sig(smp_sig), .pix_valid(pix_valid),
      .col(col), .row(row), .line_end(line_end), .frame_end(frame_end),
      .busy(busy), .err(err), .cds_out(cds_out), .cds_valid(cds_valid)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Drive one cycle's inputs just after the rising edge, return at the falling edge for sampling.
   task automatic tick(input logic en, input logic p, input logic l1, input logic l2, input logic r);
      @(posedge clk);
      #1;
      enable = en; phi_p = p; phi_l1 = l1; phi_l2 = l2; phi_r = r;
      @(negedge clk);
   endtask

   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (smp_rst || smp_sig)
            chk("strobe_excl", {30'd0, smp_rst & smp_sig, pix_valid ^ smp_sig}, 32'd0);
         if (pix_valid) npix++;
         if (line_end) nle++;
         if (frame_end) nfe++;
      end
   end

   task automatic row_pulse();
      tick(1, 1, 0, 0, 0);
      tick(1, 0, 0, 0, 0);
   endtask

   // One pixel: phi_r pulse then phi_l1 pulse, measuring strobe latencies and position/markers.
   task automatic pix(input logic [7:0] c, input logic [7:0] r, input logic le, input logic fe,
                      input logic [ADC_W-1:0] a_rst, input logic [ADC_W-1:0] a_sig);
      int off, n;
      logic prev_sig;
      logic exp_cv;
      logic [ADC_W-1:0] exp_cds;
`ifdef CDS_SUB_EN
      exp_cv  = 1'b1;
      exp_cds = (a_rst > a_sig) ? a_rst - a_sig : '0;
`else
      exp_cv  = 1'b0;
      exp_cds = '0;
`endif
      adc_data = a_rst;
      tick(1, 0, 0, 0, 1);
      tick(1, 0, 0, 0, 0);
      off = -1; n = 0;
      for (int i = 1; i <= 5; i++) begin
         tick(1, 0, 0, 0, 0);
         if (smp_rst) begin
            n++;
            if (off < 0) off = i;
            chk("rst_pos", {16'd0, col, row}, {16'd0, c, r});
         end
      end
      chk("rst_dly", off, RST_DLY);
      chk("rst_count", n, 1);
      adc_data = a_sig;
      tick(1, 0, 1, 0, 0);
      tick(1, 0, 0, 0, 0);
      off = -1; n = 0; prev_sig = 1'b0;
      for (int i = 1; i <= 6; i++) begin
         tick(1, 0, 0, 0, 0);
         if (prev_sig) chk("cds", {19'd0, cds_valid, cds_out}, {19'd0, exp_cv, exp_cds});
         prev_sig = smp_sig;
         if (smp_sig) begin
            n++;
            if (off < 0) off = i;
            chk("sig_pos", {14'd0, col, row, line_end, frame_end}, {14'd0, c, r, le, fe});
         end
      end
      chk("sig_dly", off, SIG_DLY);
      chk("sig_count", n, 1);
   endtask

   typedef struct packed {
      logic       en, p, l1, l2, r;
      logic [6:0] e_flags;   // {smp_rst, smp_sig, pix_valid, line_end, frame_end, busy, err}
      logic [7:0] e_col, e_row;
   } vec_t;

   vec_t tbl [16];

   initial begin
      int le_snap;
      tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'b0000000, 8'd0, 8'd0};
      tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 7'b0000000, 8'd0, 8'd0};
      tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 7'b0000010, 8'd0, 8'd0};
      tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7'b0000010, 8'd0, 8'd0};
      tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 7'b0000010, 8'd0, 8'd0};
      tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7'b0000010, 8'd0, 8'd0};
      tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7'b0000010, 8'd0, 8'd0};
      tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7'b1000010, 8'd0, 8'd0};
      tbl[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 7'b0000010, 8'd0, 8'd0};
      tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7'b0000010, 8'd0, 8'd0};
      tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7'b0000010, 8'd0, 8'd0};
      tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7'b0000010, 8'd0, 8'd0};
      tbl[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7'b0110010, 8'd0, 8'd0};
      tbl[13] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7'b0000010, 8'd1, 8'd0};
      tbl[14] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 7'b0000010, 8'd1, 8'd0};
      tbl[15] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7'b0000010, 8'd1, 8'd0};

      // Reset held with toggling phases, then idle with enable low.
      for (int i = 0; i < 6; i++) begin
         if (i == 3) rst_n = 1'b1;
         tick(0, (i % 2) == 1, (i % 2) == 0, (i % 2) == 1, (i % 2) == 0);
         chk("reset_idle", {smp_rst, smp_sig, pix_valid, line_end, frame_end, busy, err,
                            col, row, cds_valid, cds_out}, 32'd0);
      end

      // First pixel, cycle by cycle.
      for (int i = 0; i < 16; i++) begin
         tick(tbl[i].en, tbl[i].p, tbl[i].l1, tbl[i].l2, tbl[i].r);
         chk($sformatf("vec%0d", i),
             {9'd0, smp_rst, smp_sig, pix_valid, line_end, frame_end, busy, err, col, row},
             {9'd0, tbl[i].e_flags, tbl[i].e_col, tbl[i].e_row});
      end

      // Remainder of the nominal 4x2 frame.
      pix(8'd1, 8'd0, 1'b0, 1'b0, '0, '0);
      pix(8'd2, 8'd0, 1'b0, 1'b0, '0, '0);
      pix(8'd3, 8'd0, 1'b1, 1'b0, '0, '0);
      row_pulse();
      pix(8'd0, 8'd1, 1'b0, 1'b0, '0, '0);
      pix(8'd1, 8'd1, 1'b0, 1'b0, '0, '0);
      pix(8'd2, 8'd1, 1'b0, 1'b0, '0, '0);
      pix(8'd3, 8'd1, 1'b1, 1'b1, '0, '0);
      tick(1, 0, 0, 0, 0);
      chk("frame_wrap", {15'd0, busy, col, row}, {15'd0, 1'b1, 8'd0, 8'd0});
      chk("pix_count", npix, 8);
      chk("line_end_count", nle, 2);
      chk("frame_end_count", nfe, 1);

      // Short line: row transfer after the second pixel of row 0.
      row_pulse();
      pix(8'd0, 8'd0, 1'b0, 1'b0, '0, '0);
      pix(8'd1, 8'd0, 1'b0, 1'b0, '0, '0);
      le_snap = nle;
      tick(1, 1, 0, 0, 0);
      tick(1, 0, 0, 0, 0);
      chk("short_err", {29'd0, err, line_end, smp_sig}, {29'd0, 3'b100});
      pix(8'd0, 8'd1, 1'b0, 1'b0, '0, '0);
      chk("short_no_line_end", nle, le_snap);
      chk("short_err_sticky", {31'd0, err}, 32'd1);

      // Enable drop while the reset-level strobe is pending.
      tick(1, 0, 0, 0, 1);
      tick(1, 0, 0, 0, 0);
      tick(1, 0, 0, 0, 0);
      tick(0, 0, 0, 0, 0);
      chk("drop_no_strobe", {31'd0, smp_rst}, 32'd0);
      tick(0, 0, 0, 0, 0);
      chk("drop_cleared", {busy, err, col, row, cds_valid, cds_out}, 32'd0);

      // Stray phi_r fall while waiting for the signal phase.
      tick(1, 0, 0, 0, 0);
      row_pulse();
      tick(1, 0, 0, 0, 1);
      tick(1, 0, 0, 0, 0);
      tick(1, 0, 0, 0, 0);
      tick(1, 0, 0, 0, 0);
      tick(1, 0, 0, 0, 0);
      chk("stray_r_before", {31'd0, err}, 32'd0);
      tick(1, 0, 0, 0, 1);
      tick(1, 0, 0, 0, 0);
      chk("stray_r_err", {31'd0, err}, 32'd1);

      // Phase overlap: one cycle tolerated, two cycles flagged.
      tick(0, 0, 0, 0, 0);
      tick(0, 0, 0, 0, 0);
      chk("ovl_cleared", {31'd0, err}, 32'd0);
      tick(1, 0, 0, 0, 0);
      tick(1, 0, 1, 1, 0);
      chk("ovl_single_a", {31'd0, err}, 32'd0);
      tick(1, 0, 0, 0, 0);
      chk("ovl_single_b", {31'd0, err}, 32'd0);
      tick(1, 0, 1, 1, 0);
      chk("ovl_first", {31'd0, err}, 32'd0);
      tick(1, 0, 1, 1, 0);
      chk("ovl_second", {31'd0, err}, 32'd1);
      tick(1, 0, 0, 0, 0);
      tick(1, 0, 0, 0, 0);
      chk("ovl_sticky", {31'd0, err}, 32'd1);

      // CDS subtraction: positive difference and saturation to zero.
      tick(0, 0, 0, 0, 0);
      tick(1, 0, 0, 0, 0);
      row_pulse();
      pix(8'd0, 8'd0, 1'b0, 1'b0, 12'h800, 12'h300);
      pix(8'd1, 8'd0, 1'b0, 1'b0, 12'h200, 12'h300);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
